// File: rtl/logic_op_pkg.sv
// Shared types for the bitwise logic pipeline: function select codes and result flags.
package logic_op_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_OR   = 3'd0,
    OP_AND  = 3'd1,
    OP_NAND = 3'd2,
    OP_XOR  = 3'd3,
    OP_NOT  = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef struct packed {
    logic zero;
    logic parity;
  } flags_t;

endpackage

// File: rtl/logic_op_stage.sv
// One valid/ready register slice: loads when empty or when its contents leave
// the same cycle, otherwise holds data unchanged.
module logic_op_stage #(
  parameter int unsigned     DW      = 8,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          load_ok_c,
  input  logic [DW-1:0] d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q
);

  logic load_c;

  assign load_ok_c = !out_valid || out_ready;
  assign load_c    = in_valid && load_ok_c;

  // When the slot is free, validity simply follows the upstream valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= RST_VAL;
    end else begin
      if (load_ok_c) out_valid <= in_valid;
      if (load_c)    q         <= d;
    end
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready pipeline applying one of eight bitwise functions to
// WIDTH-bit operands, with zero/parity flags and a delivered-result counter.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] ops_done
);

  localparam int unsigned S2_W = WIDTH + $bits(flags_t);
  localparam logic [S2_W-1:0] S2_RST = {WIDTH'(0), 1'b1, 1'b0};

  logic [WIDTH-1:0] f_c;
  logic [WIDTH-1:0] s1_res;
  logic             s1_valid;
  logic             s2_load_ok;
  flags_t           flags_c;
  flags_t           s2_flags;

  // Function decode on the raw operands.
  always_comb begin
    f_c = b;
    case (op_e'(op))
      OP_OR:   f_c = a | b;
      OP_AND:  f_c = a & b;
      OP_NAND: f_c = ~(a & b);
      OP_XOR:  f_c = a ^ b;
      OP_NOT:  f_c = ~a;
      OP_NOR:  f_c = ~(a | b);
      OP_XNOR: f_c = ~(a ^ b);
      OP_PASS: f_c = b;
      default: f_c = b;
    endcase
  end

  logic_op_stage #(
    .DW      (WIDTH),
    .RST_VAL ('0)
  ) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .load_ok_c (in_ready),
    .d         (f_c),
    .out_valid (s1_valid),
    .out_ready (s2_load_ok),
    .q         (s1_res)
  );

  // Flags are computed from the S1 result so they register alongside y.
  always_comb begin
    flags_c        = '0;
    flags_c.zero   = ~|s1_res;
    flags_c.parity = ^s1_res;
  end

  logic_op_stage #(
    .DW      (S2_W),
    .RST_VAL (S2_RST)
  ) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .load_ok_c (s2_load_ok),
    .d         ({s1_res, flags_c}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         ({y, s2_flags})
  );

  assign zero   = s2_flags.zero;
  assign parity = s2_flags.parity;

  // Counts output handshakes; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops_done <= '0;
    end else if (out_valid && out_ready) begin
      ops_done <= ops_done + CNT_W'(1);
    end
  end

endmodule
